// File: rtl/vx_lru_set_if.sv
// vx_lru_set_if: bus bundle for the LRU-ordered tag set.
//   master: drives push/data_in, pop, touch/touch_data; observes the rest.
//   slave : the set itself; drives touch_hit, data_out, eviction port, flags, size.
interface vx_lru_set_if #(
  parameter int DATAW = 8,
  parameter int SIZEW = 3
);
  logic             push;
  logic [DATAW-1:0] data_in;
  logic             pop;
  logic             touch;
  logic [DATAW-1:0] touch_data;
  logic             touch_hit;
  logic [DATAW-1:0] data_out;
  logic             evict_valid;
  logic [DATAW-1:0] evict_data;
  logic             empty;
  logic             full;
  logic             alm_full;
  logic [SIZEW-1:0] size;

  modport master (
    output push, data_in, pop, touch, touch_data,
    input  touch_hit, data_out, evict_valid, evict_data, empty, full, alm_full, size
  );

  modport slave (
    input  push, data_in, pop, touch, touch_data,
    output touch_hit, data_out, evict_valid, evict_data, empty, full, alm_full, size
  );
endinterface

// File: rtl/vx_lru_set.sv
// vx_lru_set: recency-ordered set of DATAW-bit tags (slot 0 = LRU).
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   bus      - vx_lru_set_if.slave: push/data_in, pop, touch/touch_data in;
//              touch_hit, data_out (LRU), evict_valid/evict_data, empty,
//              full, alm_full, size out.
// Same-cycle operations resolve as touch, then pop, then push; all of the
// combinational outputs are derived from that same chain.
module vx_lru_set #(
  parameter int DATAW         = 8,
  parameter int DEPTH         = 4,
  parameter int ALM_FULL      = DEPTH - 1,
  parameter int EVICT_ON_FULL = 1,
  parameter int DEDUP         = 0,
  parameter int SIZEW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  vx_lru_set_if.slave   bus
);

  typedef logic [DEPTH-1:0][DATAW-1:0] list_t;

  // Slots at or beyond size_reg are always zero, so data_out reads 0 when empty.
  list_t            mem_reg;
  logic [SIZEW-1:0] size_reg;
  logic             empty_reg;
  logic             full_reg;
  logic             alm_full_reg;

  list_t            t_list;
  list_t            p_list;
  list_t            n_list;
  int               size_i;
  int               p_size;
  int               n_size;
  logic             t_hit;
  logic             do_pop;
  logic             ev;
  logic             push_dropped;
  logic [DEPTH-1:0] touch_match;
  logic [DEPTH-1:0] dedup_match;

  // Lowest set bit wins, so the oldest duplicate is the one promoted.
  function automatic int lowest(input logic [DEPTH-1:0] v);
    int idx;
    idx = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Move entry k to slot cnt-1 (MRU); entries k+1..cnt-1 slide down one.
  function automatic list_t promote(input list_t l, input int k, input int cnt);
    list_t            r;
    logic [DATAW-1:0] moved;
    r     = l;
    moved = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == k) moved = l[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (i >= k && i < cnt - 1) r[i] = l[i + 1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i == cnt - 1) r[i] = moved;
    end
    return r;
  endfunction

  // Drop slot 0; the top slot is zero-filled to keep the "unused = 0" invariant.
  function automatic list_t shift_out(input list_t l);
    list_t r;
    for (int i = 0; i < DEPTH - 1; i++) r[i] = l[i + 1];
    r[DEPTH-1] = '0;
    return r;
  endfunction

  function automatic list_t place(input list_t l, input int idx, input logic [DATAW-1:0] val);
    list_t r;
    r = l;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == idx) r[i] = val;
    end
    return r;
  endfunction

  // Touch compares against registered state only: no path from push/pop to touch_hit.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_touch_match
      assign touch_match[gi] = (SIZEW'(gi) < size_reg) && (mem_reg[gi] == bus.touch_data);
    end
  endgenerate

  // Stage 1: touch, then pop on the post-touch list.
  always_comb begin
    size_i = int'(size_reg);
    t_hit  = bus.touch && (|touch_match);
    t_list = mem_reg;
    if (t_hit) t_list = promote(mem_reg, lowest(touch_match), size_i);
    do_pop = bus.pop && (size_i != 0);
    p_list = t_list;
    p_size = size_i;
    if (do_pop) begin
      p_list = shift_out(t_list);
      p_size = size_i - 1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dedup_match
      assign dedup_match[gi] = (gi < p_size) && (p_list[gi] == bus.data_in);
    end
  endgenerate

  // Stage 2: push on the post-pop list.
  always_comb begin
    n_list       = p_list;
    n_size       = p_size;
    ev           = 1'b0;
    push_dropped = 1'b0;
    if (bus.push) begin
      if (DEDUP != 0 && (|dedup_match)) begin
        n_list = promote(p_list, lowest(dedup_match), p_size);
      end else if (p_size < DEPTH) begin
        n_list = place(p_list, p_size, bus.data_in);
        n_size = p_size + 1;
      end else if (EVICT_ON_FULL != 0) begin
        // Full with no pop: p_list equals t_list, so slot 0 is the post-touch LRU.
        ev     = 1'b1;
        n_list = place(shift_out(p_list), DEPTH - 1, bus.data_in);
      end else begin
        push_dropped = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_reg      <= '0;
      size_reg     <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      alm_full_reg <= 1'b0;
    end else begin
      mem_reg      <= n_list;
      size_reg     <= SIZEW'(n_size);
      empty_reg    <= (n_size == 0);
      full_reg     <= (n_size == DEPTH);
      alm_full_reg <= (n_size >= ALM_FULL);
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.pop && size_reg == '0)) else $error("vx_lru_set: pop on empty set");
      assert (!push_dropped) else $error("vx_lru_set: push to full set dropped");
    end
  end

  assign bus.touch_hit   = t_hit;
  assign bus.evict_valid = ev;
  assign bus.evict_data  = ev ? t_list[0] : '0;
  assign bus.data_out    = mem_reg[0];
  assign bus.empty       = empty_reg;
  assign bus.full        = full_reg;
  assign bus.alm_full    = alm_full_reg;
  assign bus.size        = size_reg;

endmodule

// File: tb/tb_vx_lru_set.sv
// tb_vx_lru_set: two instances (DEDUP=0 and DEDUP=1, both evict-on-full)
// share one stimulus stream; each is compared against a queue-based model.
module tb_vx_lru_set;
  localparam int DATAW = 8;
  localparam int DEPTH = 4;
  localparam int SIZEW = 3;
  localparam int ALMF  = DEPTH - 1;

  logic clk;
  logic reset_n;
  logic             drv_push;
  logic [DATAW-1:0] drv_data;
  logic             drv_pop;
  logic             drv_touch;
  logic [DATAW-1:0] drv_tdata;

  int checks = 0;
  int errors = 0;

  logic [DATAW-1:0] q0[$];
  logic [DATAW-1:0] q1[$];

  vx_lru_set_if #(.DATAW(DATAW), .SIZEW(SIZEW)) if0 ();
  vx_lru_set_if #(.DATAW(DATAW), .SIZEW(SIZEW)) if1 ();

  assign if0.push = drv_push;   assign if1.push = drv_push;
  assign if0.data_in = drv_data; assign if1.data_in = drv_data;
  assign if0.pop = drv_pop;     assign if1.pop = drv_pop;
  assign if0.touch = drv_touch; assign if1.touch = drv_touch;
  assign if0.touch_data = drv_tdata; assign if1.touch_data = drv_tdata;

  vx_lru_set #(.DATAW(DATAW), .DEPTH(DEPTH), .EVICT_ON_FULL(1), .DEDUP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave));
  vx_lru_set #(.DATAW(DATAW), .DEPTH(DEPTH), .EVICT_ON_FULL(1), .DEDUP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a recency list as a plain queue, front = least recently used.
  task automatic model(input bit dedup, input logic [DATAW-1:0] qi[$],
                       input logic p, input logic [DATAW-1:0] d, input logic o,
                       input logic t, input logic [DATAW-1:0] td,
                       output logic [DATAW-1:0] qo[$], output logic th,
                       output logic ev, output logic [DATAW-1:0] ed);
    int idx;
    logic [DATAW-1:0] v;
    qo = qi; th = 1'b0; ev = 1'b0; ed = '0;
    if (t) begin
      idx = -1;
      for (int i = 0; i < qo.size(); i++) if (idx < 0 && qo[i] == td) idx = i;
      if (idx >= 0) begin
        th = 1'b1; v = qo[idx]; qo.delete(idx); qo.push_back(v);
      end
    end
    if (o && qo.size() > 0) void'(qo.pop_front());
    if (p) begin
      idx = -1;
      if (dedup) for (int i = 0; i < qo.size(); i++) if (idx < 0 && qo[i] == d) idx = i;
      if (idx >= 0) begin
        v = qo[idx]; qo.delete(idx); qo.push_back(v);
      end else if (qo.size() < DEPTH) begin
        qo.push_back(d);
      end else begin
        ev = 1'b1; ed = qo.pop_front(); qo.push_back(d);
      end
    end
  endtask

  task automatic check_state(input string n, input logic [DATAW-1:0] q[$],
                             input logic [DATAW-1:0] dout, input logic [SIZEW-1:0] sz,
                             input logic e, input logic f, input logic a);
    logic [DATAW-1:0] exp_do;
    exp_do = (q.size() > 0) ? q[0] : '0;
    chk({n, " data_out"}, dout, exp_do);
    chk({n, " size"}, sz, q.size());
    chk({n, " empty"}, e, q.size() == 0);
    chk({n, " full"}, f, q.size() == DEPTH);
    chk({n, " alm_full"}, a, q.size() >= ALMF);
  endtask

  task automatic step(input logic p, input logic [DATAW-1:0] d, input logic o,
                      input logic t, input logic [DATAW-1:0] td);
    logic [DATAW-1:0] nq0[$];
    logic [DATAW-1:0] nq1[$];
    logic th0, ev0, th1, ev1;
    logic [DATAW-1:0] ed0, ed1;
    @(negedge clk);
    drv_push = p; drv_data = d; drv_pop = o; drv_touch = t; drv_tdata = td;
    model(1'b0, q0, p, d, o, t, td, nq0, th0, ev0, ed0);
    model(1'b1, q1, p, d, o, t, td, nq1, th1, ev1, ed1);
    #1;
    chk("d0 touch_hit", if0.touch_hit, th0);
    chk("d0 evict_valid", if0.evict_valid, ev0);
    if (ev0) chk("d0 evict_data", if0.evict_data, ed0);
    chk("d1 touch_hit", if1.touch_hit, th1);
    chk("d1 evict_valid", if1.evict_valid, ev1);
    if (ev1) chk("d1 evict_data", if1.evict_data, ed1);
    @(posedge clk);
    q0 = nq0; q1 = nq1;
    #1;
    check_state("d0", q0, if0.data_out, if0.size, if0.empty, if0.full, if0.alm_full);
    check_state("d1", q1, if1.data_out, if1.size, if1.empty, if1.full, if1.alm_full);
    $display("step push=%0d din=%02h pop=%0d touch=%0d tdata=%02h | d0 size=%0d lru=%02h | d1 size=%0d lru=%02h",
             p, d, o, t, td, if0.size, if0.data_out, if1.size, if1.data_out);
    drv_push = 1'b0; drv_pop = 1'b0; drv_touch = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    q0.delete(); q1.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic rp, ro, rt;
  logic [DATAW-1:0] rd, rtd;

  initial begin
    reset_n = 1'b0;
    drv_push = 1'b0; drv_data = '0; drv_pop = 1'b0; drv_touch = 1'b0; drv_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset d0", q0, if0.data_out, if0.size, if0.empty, if0.full, if0.alm_full);
    check_state("reset d1", q1, if1.data_out, if1.size, if1.empty, if1.full, if1.alm_full);
    chk("reset touch_hit idle", if0.touch_hit, 1'b0);
    chk("reset evict_valid idle", if0.evict_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset in the middle of traffic.
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    q0.delete(); q1.delete();
    chk("async rst size", if0.size, 0);
    chk("async rst empty", if0.empty, 1'b1);
    chk("async rst data_out", if0.data_out, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 8'h33, 0, 0, 0);
    chk("post rst data_out", if0.data_out, 8'h33);
    chk("post rst size", if0.size, 1);

    // Fill order, then pop everything.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'h0A + 8'(i), 0, 0, 0);
    chk("fill full", if0.full, 1'b1);
    chk("fill lru", if0.data_out, 8'h0A);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("drain empty", if0.empty, 1'b1);

    // Touch hit and touch miss; drain to expose the order.
    for (int i = 0; i < 4; i++) step(1, 8'h0A + 8'(i), 0, 0, 0);
    step(0, 0, 0, 1, 8'h0B);
    step(0, 0, 0, 1, 8'h0E);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

    // Touch on the LRU together with pop.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'h0A + 8'(i), 0, 0, 0);
    step(0, 0, 1, 1, 8'h0A);
    chk("touch+pop lru", if0.data_out, 8'h0C);
    chk("touch+pop size", if0.size, 2);

    // Eviction on full, then push+pop while full.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'h0A + 8'(i), 0, 0, 0);
    step(1, 8'h0E, 0, 0, 0);
    chk("evict lru", if0.data_out, 8'h0B);
    step(1, 8'h0F, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

    // De-duplicating push (instance 1) versus plain append (instance 0).
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'h0A + 8'(i), 0, 0, 0);
    step(1, 8'h0A, 0, 0, 0);
    chk("dedup size", if1.size, 3);
    chk("dedup lru", if1.data_out, 8'h0B);
    chk("nodedup size", if0.size, 4);

    // Random traffic over a small tag space so hits and duplicates are common.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      rp  = ($urandom_range(0, 1) == 1);
      rd  = 8'($urandom_range(0, 7));
      ro  = ($urandom_range(0, 2) == 0) && (q0.size() > 0) && (q1.size() > 0);
      rt  = ($urandom_range(0, 1) == 1);
      rtd = 8'($urandom_range(0, 7));
      step(rp, rd, ro, rt, rtd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
